conv_layer_ctrl: RTL
====================

CONV_LAYER_CTRL -- requirements
Module: conv_layer_ctrl

Interface
REQ-001 Parameters (name, default, meaning), one per line:
- IN_CH, 6, input channels.
- OUT_CH, 16, output channels.
- IN_DIM, 14, input plane side.
- K, 5, kernel side.
- DATA_W, 16, signed fixed-point word width.
- FRAC_W, 8, fractional bits.
- ACC_W, 40, accumulator width.
- FM_AW, 11, feature-map address width.
- W_AW, 12, weight address width.
- B_AW, 7, bias address width.
- OUT_AW, 11, output address width.
REQ-002 Derived values: OD = IN_DIM-K+1; N = IN_CH*K*K MACs per pixel; P = OUT_CH*OD*OD pixels.
REQ-003 Ports (name, direction, width, meaning), one per line:
- clk, in, 1, sole clock, rising edge.
- rst, in, 1, synchronous active-high reset.
- start, in, 1, begin layer pass.
- busy, out, 1, pass in progress.
- bias_bram_en, out, 1, bias read enable.
- bias_bram_addr, out, B_AW, bias address.
- bias_bram_dout, in, DATA_W, bias data, valid 1 cycle after enable.
- fm_bram_en, out, 1, feature-map read enable.
- fm_bram_addr, out, FM_AW, feature-map address.
- fm_bram_dout, in, DATA_W, feature-map data, 1-cycle latency.
- w_bram_en, out, 1, weight read enable.
- w_bram_addr, out, W_AW, weight address.
- w_bram_dout, in, DATA_W, weight data, 1-cycle latency.
- out_bram_we, out, 1, output write strobe.
- out_bram_addr, out, OUT_AW, output address.
- out_bram_din, out, DATA_W, output data.
- conv_finish, out, 1, one-cycle pulse at end of pass.

Function
REQ-004 States: IDLE, BIAS, MAC, DRAIN, WRITE, DONE.
REQ-005 IDLE with start=1 SHALL go to BIAS next cycle; start in any other state SHALL be ignored.
REQ-006 BIAS (1 cycle) SHALL assert bias_bram_en with bias_bram_addr=oc.
REQ-007 MAC (N cycles) SHALL assert fm_bram_en and w_bram_en every cycle, iterating kc fastest, then kr, then ic.
REQ-008 Read address formulas:
- fm_bram_addr = ic*IN_DIM*IN_DIM + (r+kr)*IN_DIM + (c+kc).
- w_bram_addr = ((oc*IN_CH+ic)*K+kr)*K+kc.
REQ-009 First MAC cycle SHALL load acc = sign-extended bias << FRAC_W.
REQ-010 Each later MAC cycle and the single DRAIN cycle SHALL add the signed 2*DATA_W-bit product of the previous cycle's read data to acc.
REQ-011 WRITE (1 cycle) SHALL assert out_bram_we with out_bram_addr = oc*OD*OD + r*OD + c and out_bram_din = saturate(acc >>> FRAC_W) to signed DATA_W range [0x8000..0x7FFF at default].
REQ-012 After WRITE, c increments, wrapping to 0 at OD and incrementing r. r wraps at OD, incrementing oc. After the last pixel (oc=OUT_CH-1, r=c=OD-1) the FSM SHALL enter DONE, otherwise BIAS.
REQ-013 DONE SHALL pulse conv_finish for exactly one cycle, then return to IDLE.
REQ-014 busy SHALL be 1 in every state except IDLE.
REQ-015 Timing with start sampled at cycle 0: each pixel takes N+3 cycles; the k-th write occurs at cycle k*(N+3); conv_finish=1 at cycle P*(N+3)+1.
REQ-016 All enables and out_bram_we SHALL be 0 outside their states.

Reset
REQ-017 rst=1 SHALL, on the next edge, force IDLE and clear oc, r, c, ic, kr, kc and acc. It SHALL drive every enable, out_bram_we, busy and conv_finish to 0, and all address and data outputs to 0.
REQ-018 rst mid-pass SHALL abort with no further writes and no conv_finish; rst has priority over start.

Configuration
REQ-019 CONV_RELU_EN defined: the saturated result SHALL be clamped to 0 when negative before out_bram_din. Undefined: signed saturated values are written unmodified.

Verification
REQ-020 Bench parameters IN_CH=1, OUT_CH=1, IN_DIM=3, K=2 (N=4, P=4); all fm=0x0100, all weights=0x0100, bias=0 -> four writes of 0x0400 to addrs 0..3 at cycles 7, 14, 21, 28; conv_finish at cycle 29.
REQ-021 Same config, all fm=0x7F00, all weights=0x7F00 -> every out_bram_din=0x7FFF (saturation).
REQ-022 Weights=0, bias=0xFF00 -> out_bram_din=0x0000 with CONV_RELU_EN, 0xFF00 without.
REQ-023 start pulsed again at cycle 5 -> ignored, identical write sequence, a single conv_finish.
REQ-024 rst asserted at cycle 10 -> next cycle busy=0 and all enables 0; no writes until a new start; a fresh pass then matches REQ-020.
REQ-025 Default LeNet parameters with ramp data -> 1600 writes matching the golden model; conv_finish at cycle 244801.

Source files
------------

// File: rtl/conv_layer_ctrl.sv
// conv_layer_ctrl: sequencer for one convolution layer pass.
// For each output pixel (oc, r, c) it reads the bias, then runs one multiply-
// accumulate per (ic, kr, kc) tap against feature-map and weight BRAMs. The sum
// is rescaled, saturated and written to the output BRAM.
// Optional build macro: CONV_RELU_EN clamps negative results to zero before the write.
module conv_layer_ctrl #(
  parameter int IN_CH  = 6,
  parameter int OUT_CH = 16,
  parameter int IN_DIM = 14,
  parameter int K      = 5,
  parameter int DATA_W = 16,
  parameter int FRAC_W = 8,
  parameter int ACC_W  = 40,
  parameter int FM_AW  = 11,
  parameter int W_AW   = 12,
  parameter int B_AW   = 7,
  parameter int OUT_AW = 11
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              busy,
  output logic              bias_bram_en,
  output logic [B_AW-1:0]   bias_bram_addr,
  input  logic [DATA_W-1:0] bias_bram_dout,
  output logic              fm_bram_en,
  output logic [FM_AW-1:0]  fm_bram_addr,
  input  logic [DATA_W-1:0] fm_bram_dout,
  output logic              w_bram_en,
  output logic [W_AW-1:0]   w_bram_addr,
  input  logic [DATA_W-1:0] w_bram_dout,
  output logic              out_bram_we,
  output logic [OUT_AW-1:0] out_bram_addr,
  output logic [DATA_W-1:0] out_bram_din,
  output logic              conv_finish,
  output logic [2:0]        dbg_state
);

  // Handshake: start is a single-cycle request honoured only while busy=0;
  // busy stays high from the cycle after start until conv_finish has pulsed.
  // BRAM reads have a fixed one-cycle latency and need no back-pressure.

  localparam int OD = IN_DIM - K + 1;

  localparam logic [15:0] K_LAST  = 16'(K - 1);
  localparam logic [15:0] IC_LAST = 16'(IN_CH - 1);
  localparam logic [15:0] OD_LAST = 16'(OD - 1);
  localparam logic [15:0] OC_LAST = 16'(OUT_CH - 1);

  localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_BIAS  = 3'd1,
    S_MAC   = 3'd2,
    S_DRAIN = 3'd3,
    S_WRITE = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  state_t state, state_nx;

  logic [15:0] oc, r, c, ic, kr, kc;
  logic signed [ACC_W-1:0] acc;

  logic mac_last, pix_last, first_mac;
  logic signed [2*DATA_W-1:0] prod;
  logic signed [ACC_W-1:0] prod_ext, bias_ext, acc_sh;
  logic [DATA_W-1:0] sat_val, out_val;

  assign mac_last  = (ic == IC_LAST) && (kr == K_LAST) && (kc == K_LAST);
  assign pix_last  = (oc == OC_LAST) && (r == OD_LAST) && (c == OD_LAST);
  assign first_mac = (ic == 16'd0) && (kr == 16'd0) && (kc == 16'd0);
  assign prod      = $signed(fm_bram_dout) * $signed(w_bram_dout);
  assign prod_ext  = {{(ACC_W-2*DATA_W){prod[2*DATA_W-1]}}, prod};
  assign bias_ext  = {{(ACC_W-DATA_W){bias_bram_dout[DATA_W-1]}}, bias_bram_dout};
  assign dbg_state = state;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  // Next-state decode.
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (start) state_nx = S_BIAS;
      S_BIAS:  state_nx = S_MAC;
      S_MAC:   if (mac_last) state_nx = S_DRAIN;
      S_DRAIN: state_nx = S_WRITE;
      S_WRITE: state_nx = pix_last ? S_DONE : S_BIAS;
      S_DONE:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // Loop counters: taps advance every MAC cycle, pixels advance on WRITE.
  always_ff @(posedge clk) begin
    if (rst || (state == S_IDLE && start)) begin
      oc <= '0; r <= '0; c <= '0;
      ic <= '0; kr <= '0; kc <= '0;
    end else begin
      if (state == S_MAC) begin
        if (kc == K_LAST) begin
          kc <= '0;
          if (kr == K_LAST) begin
            kr <= '0;
            ic <= (ic == IC_LAST) ? 16'd0 : ic + 16'd1;
          end else begin
            kr <= kr + 16'd1;
          end
        end else begin
          kc <= kc + 16'd1;
        end
      end
      if (state == S_WRITE) begin
        if (c == OD_LAST) begin
          c <= '0;
          if (r == OD_LAST) begin
            r  <= '0;
            oc <= (oc == OC_LAST) ? 16'd0 : oc + 16'd1;
          end else begin
            r <= r + 16'd1;
          end
        end else begin
          c <= c + 16'd1;
        end
      end
    end
  end

  // Accumulator: the first MAC cycle seeds the scaled bias; later MAC cycles and
  // DRAIN add the product of the data read one cycle earlier.
  always_ff @(posedge clk) begin
    if (rst)                               acc <= '0;
    else if (state == S_MAC && first_mac)  acc <= bias_ext <<< FRAC_W;
    else if (state == S_MAC || state == S_DRAIN) acc <= acc + prod_ext;
  end

  // Rescale and saturate the accumulator to the output word range.
  always_comb begin
    acc_sh = acc >>> FRAC_W;
    if (acc_sh > SAT_MAX)      sat_val = SAT_MAX[DATA_W-1:0];
    else if (acc_sh < SAT_MIN) sat_val = SAT_MIN[DATA_W-1:0];
    else                       sat_val = acc_sh[DATA_W-1:0];
`ifdef CONV_RELU_EN
    out_val = sat_val[DATA_W-1] ? '0 : sat_val;
`else
    out_val = sat_val;
`endif
  end

  // Per-state strobes and addresses; everything idles at zero.
  always_comb begin
    busy           = (state != S_IDLE);
    bias_bram_en   = 1'b0;
    bias_bram_addr = '0;
    fm_bram_en     = 1'b0;
    fm_bram_addr   = '0;
    w_bram_en      = 1'b0;
    w_bram_addr    = '0;
    out_bram_we    = 1'b0;
    out_bram_addr  = '0;
    out_bram_din   = '0;
    conv_finish    = 1'b0;
    case (state)
      S_BIAS: begin
        bias_bram_en   = 1'b1;
        bias_bram_addr = B_AW'(oc);
      end
      S_MAC: begin
        fm_bram_en   = 1'b1;
        w_bram_en    = 1'b1;
        fm_bram_addr = FM_AW'(32'(ic) * IN_DIM * IN_DIM + (32'(r) + 32'(kr)) * IN_DIM
                              + 32'(c) + 32'(kc));
        w_bram_addr  = W_AW'(((32'(oc) * IN_CH + 32'(ic)) * K + 32'(kr)) * K + 32'(kc));
      end
      S_WRITE: begin
        out_bram_we   = 1'b1;
        out_bram_addr = OUT_AW'(32'(oc) * OD * OD + 32'(r) * OD + 32'(c));
        out_bram_din  = out_val;
      end
      S_DONE: conv_finish = 1'b1;
      default: ;
    endcase
  end

endmodule
